// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the radix selection sort sequencer.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEARCH = 2'd2,
    EMIT   = 2'd3
  } sched_state_t;

  localparam int DEF_N = 8;
  localparam int DEF_W = 8;

  // Index width for a range of n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_eliminate.sv
// One radix step: drop candidates holding a 1 in the current column unless
// that would empty the candidate set.
module bit_eliminate #(
  parameter int N = 8
) (
  input  logic [N-1:0] chi,
  input  logic [N-1:0] bits,
  output logic [N-1:0] chi_out
);

  logic [N-1:0] z;

  always_comb begin
    z       = chi & ~bits;
    chi_out = (|z) ? z : chi;
  end

endmodule

// File: rtl/radix_sort_sched.sv
// Load N keys, then emit them in stable ascending order by bit-serial selection
// of the smallest remaining key (W search cycles plus one emit cycle per key).
module radix_sort_sched
  import sort_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int W    = DEF_W,
  parameter int IDXW = idx_width(N)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_abort,
  input  logic            i_in_valid,
  input  logic [W-1:0]    i_in_data,
  output logic            o_in_ready,
  output logic            o_out_valid,
  output logic [W-1:0]    o_out_data,
  output logic [IDXW-1:0] o_out_idx,
  input  logic            i_out_ready,
  output logic            o_busy,
  output logic            o_done,
  output sched_state_t    o_dbg_state,
  output logic [N-1:0]    o_dbg_rem
);

  localparam int BW = idx_width(W);
  localparam logic [BW-1:0]   BIT_TOP  = BW'(W - 1);
  localparam logic [IDXW-1:0] CNT_LAST = IDXW'(N - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and EMIT outputs hold until taken.

  sched_state_t    state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [IDXW-1:0] win_q, win_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    chi_q, chi_d;
  logic            done_q, done_d;
  logic [W-1:0]    key_q [N];
  logic [W-1:0]    key_d [N];

  logic [N-1:0]    col_bits;
  logic [N-1:0]    chi_nx;
  logic [N-1:0]    win_oh;
  logic [N-1:0]    rem_after;
  logic [IDXW-1:0] low_idx;
  logic            accept;

  always_comb begin
    col_bits = '0;
    win_oh   = '0;
    for (int i = 0; i < N; i++) begin
      col_bits[i] = key_q[i][bit_q];
      win_oh[i]   = (win_q == IDXW'(i));
    end
  end

  bit_eliminate #(.N(N)) u_bit_eliminate (
    .chi     (chi_q),
    .bits    (col_bits),
    .chi_out (chi_nx)
  );

  // Lowest set index of the narrowed candidates gives stable tie-breaking.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (chi_nx[i]) low_idx = IDXW'(i);
    end
  end

  always_comb begin
    o_in_ready  = (state_q == IDLE) || (state_q == LOAD);
    o_out_valid = (state_q == EMIT);
    o_out_data  = (state_q == EMIT) ? key_q[win_q] : '0;
    o_out_idx   = (state_q == EMIT) ? win_q : '0;
    o_busy      = (state_q != IDLE);
    o_done      = done_q;
    o_dbg_state = state_q;
    o_dbg_rem   = rem_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    win_d     = win_q;
    rem_d     = rem_q;
    chi_d     = chi_q;
    done_d    = 1'b0;
    key_d     = key_q;
    accept    = i_in_valid && o_in_ready;
    rem_after = rem_q & ~win_oh;

    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          key_d[cnt_q] = i_in_data;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            rem_d   = '1;
            chi_d   = '1;
            bit_d   = BIT_TOP;
            state_d = SEARCH;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      SEARCH: begin
        chi_d = chi_nx;
        if (bit_q == '0) begin
          win_d   = low_idx;
          state_d = EMIT;
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end
      EMIT: begin
        if (i_out_ready) begin
          rem_d = rem_after;
          if (rem_after == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            chi_d   = rem_after;
            bit_d   = BIT_TOP;
            state_d = SEARCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything; key storage is left as is.
    if (i_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      win_d   = '0;
      rem_d   = '0;
      chi_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      win_q   <= '0;
      rem_q   <= '0;
      chi_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N; i++) key_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      win_q   <= win_d;
      rem_q   <= rem_d;
      chi_q   <= chi_d;
      done_q  <= done_d;
      for (int i = 0; i < N; i++) key_q[i] <= key_d[i];
    end
  end

endmodule

// File: tb/tb_radix_sort_sched.sv
// Directed bench for radix_sort_sched with N=4, W=8 and hand-computed outputs.
module tb_radix_sort_sched;
  import sort_pkg::*;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int IDXW = 2;

  logic            clk;
  logic            rst_n;
  logic            abort;
  logic            in_valid;
  logic [W-1:0]    in_data;
  logic            in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [IDXW-1:0] out_idx;
  logic            out_ready;
  logic            busy;
  logic            done;
  sched_state_t    dbg_state;
  logic [N-1:0]    dbg_rem;

  int n_cmp = 0;
  int n_mis = 0;
  logic [IDXW+W-1:0] exp_q[$];

  radix_sort_sched #(.N(N), .W(W), .IDXW(IDXW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_abort     (abort),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .o_out_idx   (out_idx),
    .i_out_ready (out_ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_dbg_state (dbg_state),
    .o_dbg_rem   (dbg_rem)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_exp(input logic [IDXW-1:0] idx, input logic [W-1:0] data);
    exp_q.push_back({idx, data});
  endtask

  task automatic load_keys(input logic [W-1:0] k0, input logic [W-1:0] k1,
                           input logic [W-1:0] k2, input logic [W-1:0] k3);
    logic [W-1:0] ks [N];
    ks[0] = k0; ks[1] = k1; ks[2] = k2; ks[3] = k3;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = ks[i];
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Waits for each output with ready held high; entry point is just after the
  // accept edge of the last key (or just after a handshake edge).
  task automatic collect(input int n, input bit chk_lat, input bit last_done);
    int cyc;
    logic [IDXW+W-1:0] exp_v;
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      cyc = 0;
      while (!out_valid && cyc < 50) begin
        step();
        cyc++;
      end
      check("valid_wait", 32'(out_valid), 32'd1);
      if (chk_lat) check("latency", 32'(cyc), 32'(W));
      if (exp_q.size() == 0) begin
        check("exp_q_underflow", 32'd1, 32'd0);
        exp_v = '0;
      end else begin
        exp_v = exp_q.pop_front();
      end
      check("out_data", 32'(out_data), 32'(exp_v[W-1:0]));
      check("out_idx", 32'(out_idx), 32'(exp_v[IDXW+W-1:W]));
      step();
      if (last_done && k == n - 1) begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd1);
        step();
        check("done_clear", 32'(done), 32'd0);
      end else begin
        check("done_early", 32'(done), 32'd0);
      end
    end
  endtask

  initial begin
    logic [W-1:0]    held_data;
    logic [IDXW-1:0] held_idx;
    int cyc;

    rst_n     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2;
    do_reset();

    // basic sort with duplicates, plus latency
    push_exp(2'd1, 8'd3); push_exp(2'd3, 8'd3); push_exp(2'd0, 8'd5); push_exp(2'd2, 8'd7);
    load_keys(8'd5, 8'd3, 8'd7, 8'd3);
    check("search_state", 32'(dbg_state), 32'(SEARCH));
    check("search_in_ready", 32'(in_ready), 32'd0);
    collect(4, 1'b1, 1'b1);

    // backpressure during the first EMIT
    out_ready = 1'b0;
    push_exp(2'd1, 8'd3); push_exp(2'd3, 8'd3); push_exp(2'd0, 8'd5); push_exp(2'd2, 8'd7);
    load_keys(8'd5, 8'd3, 8'd7, 8'd3);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      step();
      cyc++;
    end
    held_data = out_data;
    held_idx  = out_idx;
    check("bp_first_data", 32'(held_data), 32'd3);
    check("bp_first_idx", 32'(held_idx), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'd3);
      check("bp_idx", 32'(out_idx), 32'd1);
      check("bp_rem", 32'(dbg_rem), 32'hF);
    end
    collect(4, 1'b0, 1'b1);

    // all-equal keys
    for (int i = 0; i < N; i++) push_exp(IDXW'(i), 8'hFF);
    load_keys(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    collect(4, 1'b1, 1'b1);

    // extreme values
    push_exp(2'd0, 8'h00); push_exp(2'd3, 8'h01); push_exp(2'd2, 8'h80); push_exp(2'd1, 8'hFF);
    load_keys(8'h00, 8'hFF, 8'h80, 8'h01);
    collect(4, 1'b1, 1'b1);

    // abort during the second search
    push_exp(2'd1, 8'd3);
    load_keys(8'd5, 8'd3, 8'd7, 8'd3);
    collect(1, 1'b1, 1'b0);
    step();
    step();
    check("pre_abort_state", 32'(dbg_state), 32'(SEARCH));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_rem", 32'(dbg_rem), 32'd0);
    check_idle_outputs("abort");
    step();
    check("abort_no_done", 32'(done), 32'd0);

    // async reset while EMIT is stalled
    out_ready = 1'b0;
    load_keys(8'd5, 8'd3, 8'd7, 8'd3);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      step();
      cyc++;
    end
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_state", 32'(dbg_state), 32'(IDLE));
    step();
    rst_n = 1'b1;
    step();

    // fresh load after reset
    push_exp(2'd3, 8'd0); push_exp(2'd1, 8'd2); push_exp(2'd2, 8'd2); push_exp(2'd0, 8'd9);
    load_keys(8'd9, 8'd2, 8'd2, 8'd0);
    collect(4, 1'b1, 1'b1);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
